// File: rtl/calc_sequencer.sv
// calc_sequencer: calculator mode FSM, operand capture and registered result; `define CALC_AUTO_CLEAR_EN to auto-clear after TIMEOUT_CYCLES idle in CALCULATE
module calc_sequencer
`ifdef CALC_AUTO_CLEAR_EN
    #(parameter int unsigned TIMEOUT_CYCLES = 100_000_000)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_clear,
    input  logic [7:0] sw,
    input  logic [1:0] op,
    output logic [1:0] state,
    output logic [7:0] num1,
    output logic [7:0] num2,
    output logic [9:0] ans,
    output logic       neg,
    output logic       ans_valid
);
    typedef enum logic [1:0] {
        WAIT        = 2'b00,
        LOAD_FIRST  = 2'b01,
        LOAD_SECOND = 2'b10,
        CALCULATE   = 2'b11
    } state_e;
    state_e     state_q, state_d;
    logic [7:0] num1_q, num1_d, num2_q, num2_d;
    logic [9:0] ans_q, ans_d, res;
    logic       neg_q, neg_d, valid_q, valid_d, res_neg;
    // {hist, sync2, sync1} per button
    logic [2:0] nxt_q, nxt_d, clr_q, clr_d;
    logic       press_next, press_clear, timeout;
    assign press_next  = nxt_q[1] & ~nxt_q[2];
    assign press_clear = clr_q[1] & ~clr_q[2];
`ifdef CALC_AUTO_CLEAR_EN
    logic [26:0] idle_q, idle_d;
    assign timeout = state_q == CALCULATE && idle_q == 27'(TIMEOUT_CYCLES - 1);
    always_comb begin
        idle_d = (state_q == CALCULATE && state_d == CALCULATE && !press_next && !press_clear) ? idle_q + 27'd1 : '0;
    end
    always_ff @(posedge clk) begin
        idle_q <= reset ? '0 : idle_d;
    end
`else
    assign timeout = 1'b0;
`endif
    assign res_neg = op == 2'b01 && num1_q < num2_q;
    assign res = op == 2'b00 ? {2'b00, num1_q} + {2'b00, num2_q} :
                 op == 2'b01 ? (res_neg ? {2'b00, num2_q - num1_q} : {2'b00, num1_q - num2_q}) :
                 op == 2'b10 ? {2'b00, num1_q} << num2_q[1:0] :
                               {2'b00, num1_q & num2_q};
    always_comb begin
        state_d = state_q;
        num1_d  = state_q == LOAD_FIRST  ? sw : num1_q;
        num2_d  = state_q == LOAD_SECOND ? sw : num2_q;
        ans_d   = state_q == CALCULATE ? res : ans_q;
        neg_d   = state_q == CALCULATE ? res_neg : neg_q;
        valid_d = state_q == CALCULATE ? 1'b1 : valid_q;
        nxt_d   = {nxt_q[1:0], btn_next};
        clr_d   = {clr_q[1:0], btn_clear};
        if (press_next) begin
            state_d = state_e'(state_q + 2'd1);
            if (state_q == WAIT) begin
                num1_d  = '0;
                num2_d  = '0;
                ans_d   = '0;
                neg_d   = 1'b0;
                valid_d = 1'b0;
            end
            if (state_q == CALCULATE) begin
                ans_d   = ans_q;
                neg_d   = neg_q;
                valid_d = 1'b0;
            end
        end
        // clear (or idle timeout) overrides any simultaneous next-press
        if (press_clear || timeout) begin
            state_d = WAIT;
            num1_d  = '0;
            num2_d  = '0;
            ans_d   = '0;
            neg_d   = 1'b0;
            valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT;
            num1_q  <= '0;
            num2_q  <= '0;
            ans_q   <= '0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
            nxt_q   <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            num1_q  <= num1_d;
            num2_q  <= num2_d;
            ans_q   <= ans_d;
            neg_q   <= neg_d;
            valid_q <= valid_d;
            nxt_q   <= nxt_d;
            clr_q   <= clr_d;
        end
    end
    assign state     = state_q;
    assign num1      = num1_q;
    assign num2      = num2_q;
    assign ans       = ans_q;
    assign neg       = neg_q;
    assign ans_valid = valid_q;
endmodule
